round_sequencer: RTL and testbench

- Core-side responder for the start/done handshake used across the crypto datapaths.
- Accepts a level-held start request from the initiator-side controller, then sequences a configurable number of datapath rounds.
- Raises a level Done_flag and holds it until the initiator drops start.
- Sits between the start/done controller and a round-based crypto core (e.g. Keccak-f, AES rounds).

---
 rtl/round_sequencer_pkg.sv | 16 +
 rtl/round_ctr.sv | 45 ++++
 rtl/round_sequencer.sv | 119 +++++++++++
 tb/tb_round_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/round_sequencer_pkg.sv
// round_sequencer_pkg
//   Shared definitions for the round sequencer slice: FSM state encodings,
//   the default round bound and the performance counter width.
package round_sequencer_pkg;

    typedef enum logic [1:0] {
        RSEQ_IDLE = 2'd0,
        RSEQ_LOAD = 2'd1,
        RSEQ_RUN  = 2'd2,
        RSEQ_DONE = 2'd3
    } rseq_state_e;

    localparam int RSEQ_MAX_ROUNDS = 24;
    localparam int RSEQ_CNT_W      = 16;

endpackage

// File: rtl/round_ctr.sv
// round_ctr
//   Round index counter with a latched round count and terminal-count compare.
//   Ports:
//     CLK, RST      clock, async active-high reset
//     ld, n_in      latch the (already clamped) round count
//     clr           clear the round index (wins over en)
//     en            advance the round index by one
//     idx           current round index
//     n_zero        latched round count is zero
//     tc            idx == n-1 (last round of the operation)
module round_ctr #(
    parameter int IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld,
    input  logic [IDX_W-1:0] n_in,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             n_zero,
    output logic             tc
);

    logic [IDX_W-1:0] n_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            n_q <= '0;
            idx <= '0;
        end else begin
            if (ld)
                n_q <= n_in;
            if (clr)
                idx <= '0;
            else if (en)
                idx <= idx + IDX_W'(1);
        end
    end

    // For n==0 the compare value wraps, but the FSM never runs rounds then.
    assign n_zero = (n_q == '0);
    assign tc     = (idx == n_q - IDX_W'(1));

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer
//   Core-side responder for the start/done handshake. Accepts a level start,
//   pulses Load, sequences up to MAX_ROUNDS rounds (honouring Stall), then
//   holds Done_flag until the initiator drops State_start.
//   Optional feature macro: ROUND_SEQ_CYCLE_COUNT_EN (Cycle_cnt counter).
//   Ports:
//     CLK, RST     clock, async active-high reset
//     State_start  level start request, held until Done_flag
//     Num_rounds   requested round count, sampled when start is accepted
//     Stall        freezes round progress while high
//     Load         one-cycle operand capture pulse
//     Round_en     core performs round Round_idx this cycle
//     Round_idx    current 0-based round number
//     Busy         operation in progress (LOAD or RUN)
//     Done_flag    operation complete, held in DONE
//     Cycle_cnt    LOAD+RUN cycle count (0 unless feature enabled)
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int MAX_ROUNDS = RSEQ_MAX_ROUNDS,
    parameter int IDX_W      = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  State_start,
    input  logic [IDX_W-1:0]      Num_rounds,
    input  logic                  Stall,
    output logic                  Load,
    output logic                  Round_en,
    output logic [IDX_W-1:0]      Round_idx,
    output logic                  Busy,
    output logic                  Done_flag,
    output logic [RSEQ_CNT_W-1:0] Cycle_cnt
);

    localparam logic [IDX_W-1:0] MAX_N = IDX_W'(MAX_ROUNDS);

    rseq_state_e      state, nxt;
    logic             ctr_ld, ctr_clr, ctr_en;
    logic             n_zero, last_round;
    logic [IDX_W-1:0] n_clamped;

    assign n_clamped = (Num_rounds > MAX_N) ? MAX_N : Num_rounds;

    round_ctr #(.IDX_W(IDX_W)) u_ctr (
        .CLK    (CLK),
        .RST    (RST),
        .ld     (ctr_ld),
        .n_in   (n_clamped),
        .clr    (ctr_clr),
        .en     (ctr_en),
        .idx    (Round_idx),
        .n_zero (n_zero),
        .tc     (last_round)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RSEQ_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt     = state;
        ctr_ld  = 1'b0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        case (state)
            RSEQ_IDLE: begin
                if (State_start) begin
                    nxt     = RSEQ_LOAD;
                    ctr_ld  = 1'b1;
                    ctr_clr = 1'b1;
                end
            end
            RSEQ_LOAD: begin
                if (!State_start) nxt = RSEQ_IDLE;
                else if (n_zero)  nxt = RSEQ_DONE;
                else              nxt = RSEQ_RUN;
            end
            RSEQ_RUN: begin
                // Abort outranks completion of the final round.
                if (!State_start) begin
                    nxt     = RSEQ_IDLE;
                    ctr_clr = 1'b1;
                end else if (!Stall) begin
                    if (last_round) nxt = RSEQ_DONE;  // index holds at n-1
                    else            ctr_en = 1'b1;
                end
            end
            RSEQ_DONE: begin
                if (!State_start) nxt = RSEQ_IDLE;
            end
            default: nxt = RSEQ_IDLE;
        endcase
    end

    assign Load      = (state == RSEQ_LOAD);
    assign Busy      = (state == RSEQ_LOAD) || (state == RSEQ_RUN);
    assign Done_flag = (state == RSEQ_DONE);
    assign Round_en  = (state == RSEQ_RUN) && !Stall;

`ifdef ROUND_SEQ_CYCLE_COUNT_EN
    logic [RSEQ_CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt_q <= '0;
        else if (state == RSEQ_IDLE && State_start)
            cnt_q <= '0;
        else if (Busy && cnt_q != '1)
            cnt_q <= cnt_q + RSEQ_CNT_W'(1);
    end

    assign Cycle_cnt = cnt_q;
`else
    assign Cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

    localparam int IDX_W = 5;
    localparam int MAXR  = 24;

    logic             CLK, RST, State_start, Stall;
    logic [IDX_W-1:0] Num_rounds;
    logic             Load, Round_en, Busy, Done_flag;
    logic [IDX_W-1:0] Round_idx;
    logic [15:0]      Cycle_cnt;

    int total = 0;
    int passed = 0;
    int failed = 0;

    round_sequencer #(.MAX_ROUNDS(MAXR), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .RST(RST), .State_start(State_start), .Num_rounds(Num_rounds),
        .Stall(Stall), .Load(Load), .Round_en(Round_en), .Round_idx(Round_idx),
        .Busy(Busy), .Done_flag(Done_flag), .Cycle_cnt(Cycle_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counter value expected when the feature is built in; 0 otherwise.
    function automatic logic [31:0] cnt_exp(input int v);
`ifdef ROUND_SEQ_CYCLE_COUNT_EN
        return (v > 65535) ? 32'hFFFF : 32'(v);
`else
        return (v >= 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_load"}, 32'(Load), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_done"}, 32'(Done_flag), 0);
        chk({tag, "_ren"},  32'(Round_en), 0);
    endtask

    // One operation, modelled as a timeline: a Load cycle, then RUN cycles in
    // which a round is retired whenever Stall is low, until n rounds are done
    // or start is dropped at RUN cycle abort_at. Starts and ends in IDLE.
    task automatic run_op(input int nreq, input int abort_at, input bit rnd,
                          input logic [63:0] smask, input int hold);
        int  n, r, j;
        bit  fin, aborted, st;
        n = (nreq > MAXR) ? MAXR : nreq;
        r = 0; j = 0; fin = 0; aborted = 0;
        State_start = 1'b1;
        Num_rounds  = IDX_W'(nreq);
        Stall       = 1'b0;
        tick();
        Num_rounds = IDX_W'($urandom);  // must be ignored from here on
        #3;
        chk("load_pulse", 32'(Load), 1);
        chk("load_busy",  32'(Busy), 1);
        chk("load_ren",   32'(Round_en), 0);
        chk("load_idx",   32'(Round_idx), 0);
        chk("load_cnt",   32'(Cycle_cnt), cnt_exp(0));
        tick();
        if (n > 0) begin
            while (!fin) begin
                st = rnd ? ($urandom_range(0, 3) == 0) : smask[j % 64];
                Stall = st;
                if (j == abort_at) State_start = 1'b0;
                #3;
                chk("run_ren",  32'(Round_en), 32'(!st));
                chk("run_idx",  32'(Round_idx), 32'(r));
                chk("run_busy", 32'(Busy), 1);
                chk("run_load", 32'(Load), 0);
                chk("run_done", 32'(Done_flag), 0);
                chk("run_cnt",  32'(Cycle_cnt), cnt_exp(j + 1));
                if (j == abort_at) begin
                    aborted = 1; fin = 1;
                end else if (!st) begin
                    r++;
                    if (r == n) fin = 1;
                end
                j++;
                tick();
                Stall = 1'b0;
                if (j > 2000) begin
                    chk("run_timeout", 32'(j), 0);
                    fin = 1; aborted = 1;
                end
            end
        end
        #3;
        if (aborted) begin
            chk_idle("abort");
            chk("abort_idx", 32'(Round_idx), 0);
            chk("abort_cnt", 32'(Cycle_cnt), cnt_exp(j + 1));
            return;
        end
        // DONE with start still held: no new Load may appear.
        for (int h = 0; h <= hold; h++) begin
            chk("done_flag", 32'(Done_flag), 1);
            chk("done_busy", 32'(Busy), 0);
            chk("done_load", 32'(Load), 0);
            chk("done_ren",  32'(Round_en), 0);
            chk("done_idx",  32'(Round_idx), (n == 0) ? 0 : 32'(n - 1));
            chk("done_cnt",  32'(Cycle_cnt), cnt_exp(j + 1));
            tick();
            #3;
        end
        State_start = 1'b0;
        chk("drop_flag", 32'(Done_flag), 1);
        tick();
        #3;
        chk_idle("post_done");
        chk("post_cnt", 32'(Cycle_cnt), cnt_exp(j + 1));
    endtask

    initial begin
        int nr, ab;
        RST = 1'b1; State_start = 1'b0; Stall = 1'b0; Num_rounds = '0;
        #3;
        chk_idle("reset");
        chk("reset_idx", 32'(Round_idx), 0);
        chk("reset_cnt", 32'(Cycle_cnt), 0);
        #19 RST = 1'b0;
        tick();
        chk_idle("idle0");

        run_op(3, -1, 0, 64'd0, 2);      // basic
        run_op(4, -1, 0, 64'b110, 1);    // stall in RUN cycles 1-2
        run_op(0, -1, 0, 64'd0, 1);      // zero rounds
        run_op(31, -1, 0, 64'd0, 0);     // clamped to MAXR
        run_op(5, 1, 0, 64'd0, 0);       // abort
        run_op(5, -1, 0, 64'd0, 0);      // restart completes normally
        run_op(2, 1, 0, 64'd0, 0);       // abort on the final round

        for (int k = 0; k < 10; k++) begin
            nr = $urandom_range(0, 31);
            ab = ($urandom_range(0, 3) == 0 && nr > 0) ? $urandom_range(0, nr) : -1;
            run_op(nr, ab, 1, 64'd0, $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of RUN.
        State_start = 1'b1;
        Num_rounds  = IDX_W'(10);
        tick(); tick(); tick();
        chk("pre_rst_busy", 32'(Busy), 1);
        #2 RST = 1'b1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_idx", 32'(Round_idx), 0);
        chk("async_rst_cnt", 32'(Cycle_cnt), 0);
        State_start = 1'b0;
        #2 RST = 1'b0;
        tick();
        #3;
        chk_idle("after_rst");

        run_op(6, -1, 1, 64'd0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
